// File: rtl/rgbw_duty_fader_pkg.sv
// Shared constants for the RGBW duty fader: default duty width, channel
// count and the colour-to-channel index map.
package rgbw_duty_fader_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int NUM_CH    = 4;

   typedef enum int {
      CH_R = 0,
      CH_G = 1,
      CH_B = 2,
      CH_W = 3
   } ch_e;

endpackage

// File: rtl/rgbw_duty_fader_if.sv
// Target/duty bus between colour generator (master) and fader (slave).
interface rgbw_duty_fader_if #(
   parameter int WIDTH  = 8,
   parameter int RATE_W = 8
);
   logic              tgt_valid;
   logic [WIDTH-1:0]  tgt0, tgt1, tgt2, tgt3;
   logic [RATE_W-1:0] rate;
   logic              bypass;
   logic [WIDTH-1:0]  duty0, duty1, duty2, duty3;
   logic              busy;
   logic              done;

   modport master (
      output tgt_valid, tgt0, tgt1, tgt2, tgt3, rate, bypass,
      input  duty0, duty1, duty2, duty3, busy, done
   );

   modport slave (
      input  tgt_valid, tgt0, tgt1, tgt2, tgt3, rate, bypass,
      output duty0, duty1, duty2, duty3, busy, done
   );
endinterface

// File: rtl/rgbw_fade_channel.sv
// One channel: latched target plus a duty register that slews toward it by
// STEP per tick, clamping at the target so it never overshoots or wraps.
module rgbw_fade_channel #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             bypass,
   input  logic             load,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] duty,
   output logic             neq
);
   localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

   logic [WIDTH-1:0] tgt_q, tgt_nxt, duty_nxt;
   logic [WIDTH:0]   up_diff, dn_diff;

   // Next duty: bypass copies the latched target; otherwise a tick moves one
   // step toward it, landing exactly on the target when within STEP.
   always_comb begin
      up_diff  = {1'b0, tgt_q} - {1'b0, duty};
      dn_diff  = {1'b0, duty} - {1'b0, tgt_q};
      duty_nxt = duty;
      tgt_nxt  = load ? target : tgt_q;
      if (bypass) begin
         duty_nxt = tgt_q;
      end else if (tick) begin
         if (tgt_q > duty)
            duty_nxt = (up_diff <= STEP_W) ? tgt_q : duty + STEP_N;
         else if (tgt_q < duty)
            duty_nxt = (dn_diff <= STEP_W) ? tgt_q : duty - STEP_N;
      end
      // Compared on next-state values so the registered busy lines up with duty.
      neq = (duty_nxt != tgt_nxt);
   end

   // Target latch and duty register.
   always_ff @(posedge clk) begin
      if (reset) begin
         tgt_q <= '0;
         duty  <= '0;
      end else begin
         tgt_q <= tgt_nxt;
         duty  <= duty_nxt;
      end
   end

endmodule

// File: rtl/rgbw_duty_fader.sv
// Four-channel duty fader: shared fade-tick counter, four slew channels,
// and busy/done status derived from the channels' convergence.
module rgbw_duty_fader
   import rgbw_duty_fader_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int STEP   = 1,
   parameter int RATE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_half,
   rgbw_duty_fader_if.slave  bus
);
   logic [NUM_CH-1:0][WIDTH-1:0] tgt_in;
   logic [NUM_CH-1:0][WIDTH-1:0] duty;
   logic [NUM_CH-1:0]            neq;
   logic [RATE_W-1:0]            cnt;
   logic                         tick;
   logic                         busy_q, busy_nxt, done_q;

   assign tgt_in[CH_R] = bus.tgt0;
   assign tgt_in[CH_G] = bus.tgt1;
   assign tgt_in[CH_B] = bus.tgt2;
   assign tgt_in[CH_W] = bus.tgt3;

   // A tick fires on the enabled cycle where the counter reaches rate.
   assign tick = clk_half && !bus.bypass && (cnt == bus.rate);

   // Tick counter: held at 0 in bypass; a counter past a lowered rate simply
   // wraps through the full range.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (bus.bypass)
         cnt <= '0;
      else if (clk_half)
         cnt <= (cnt == bus.rate) ? '0 : cnt + 1'b1;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      rgbw_fade_channel #(.WIDTH(WIDTH), .STEP(STEP)) u_ch (
         .clk    (clk),
         .reset  (reset),
         .tick   (tick),
         .bypass (bus.bypass),
         .load   (bus.tgt_valid),
         .target (tgt_in[c]),
         .duty   (duty[c]),
         .neq    (neq[c])
      );
   end

   assign busy_nxt = |neq;

   // busy follows convergence; done pulses on its falling edge except in
   // bypass, where equality is immediate and not a completed fade.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         done_q <= busy_q && !busy_nxt && !bus.bypass;
      end
   end

   assign bus.duty0 = duty[CH_R];
   assign bus.duty1 = duty[CH_G];
   assign bus.duty2 = duty[CH_B];
   assign bus.duty3 = duty[CH_W];
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_rgbw_duty_fader.sv
// Directed bench for rgbw_duty_fader: unit 0 uses STEP=1, unit 1 uses STEP=4.
// Expected outputs are queued before each clock and checked just after it.
module tb_rgbw_duty_fader;

   logic clk = 1'b0;
   logic reset;
   logic clk_half;

   always #5 clk = ~clk;

   rgbw_duty_fader_if #(.WIDTH(8), .RATE_W(8)) ia ();
   rgbw_duty_fader_if #(.WIDTH(8), .RATE_W(8)) ib ();

   rgbw_duty_fader #(.WIDTH(8), .STEP(1), .RATE_W(8)) dut_a (
      .clk(clk), .reset(reset), .clk_half(clk_half), .bus(ia));
   rgbw_duty_fader #(.WIDTH(8), .STEP(4), .RATE_W(8)) dut_b (
      .clk(clk), .reset(reset), .clk_half(clk_half), .bus(ib));

   typedef struct {
      string       tag;
      int          unit;
      logic [33:0] val;   // {duty3, duty2, duty1, duty0, busy, done}
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   function automatic logic [33:0] obs(int unit);
      if (unit == 0)
         return {ia.duty3, ia.duty2, ia.duty1, ia.duty0, ia.busy, ia.done};
      return {ib.duty3, ib.duty2, ib.duty1, ib.duty0, ib.busy, ib.done};
   endfunction

   task automatic push(input string tag, input int unit,
                       input int d0, input int d1, input int d2, input int d3,
                       input logic b, input logic dn);
      exp_t e;
      e.tag  = tag;
      e.unit = unit;
      e.val  = {8'(d3), 8'(d2), 8'(d1), 8'(d0), b, dn};
      sb.push_back(e);
   endtask

   task automatic cyc();
      exp_t        e;
      logic [33:0] o;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.unit);
         compared++;
         assert (o === e.val) else begin
            mismatched++;
            $error("FAIL %s unit%0d observed d3..d0/busy/done=%h required=%h",
                   e.tag, e.unit, o, e.val);
         end
      end
   endtask

   int seq_up[4] = '{4, 8, 10, 10};
   int seq_dn[4] = '{6, 2, 0, 0};

   initial begin
      reset = 1'b1; clk_half = 1'b1;
      ia.tgt_valid = 0; ia.tgt0 = 0; ia.tgt1 = 0; ia.tgt2 = 0; ia.tgt3 = 0;
      ia.rate = 0; ia.bypass = 0;
      ib.tgt_valid = 0; ib.tgt0 = 0; ib.tgt1 = 0; ib.tgt2 = 0; ib.tgt3 = 0;
      ib.rate = 0; ib.bypass = 0;

      // Reset for two clocks, then idle with no done on release
      repeat (2) begin
         push("reset", 0, 0, 0, 0, 0, 0, 0);
         push("reset", 1, 0, 0, 0, 0, 0, 0);
         cyc();
      end
      reset = 1'b0;
      repeat (2) begin
         push("idle", 0, 0, 0, 0, 0, 0, 0);
         push("idle", 1, 0, 0, 0, 0, 0, 0);
         cyc();
      end

      // Up fade 0 -> 10, STEP=1, rate=0
      ia.tgt_valid = 1; ia.tgt0 = 10;
      push("up_latch", 0, 0, 0, 0, 0, 1, 0);
      cyc();
      ia.tgt_valid = 0;
      for (int i = 1; i <= 10; i++) begin
         push("up_fade", 0, i, 0, 0, 0, i < 10, i == 10);
         cyc();
      end
      push("up_hold", 0, 10, 0, 0, 0, 0, 0);
      cyc();

      // No overshoot with STEP=4: 0 -> 10 then 10 -> 0
      ib.tgt_valid = 1; ib.tgt2 = 10;
      push("ovs_latch", 1, 0, 0, 0, 0, 1, 0);
      cyc();
      ib.tgt_valid = 0;
      for (int k = 0; k < 4; k++) begin
         push("ovs_up", 1, 0, 0, seq_up[k], 0, seq_up[k] != 10, k == 2);
         cyc();
      end
      ib.tgt_valid = 1; ib.tgt2 = 0;
      push("ovs_dn_latch", 1, 0, 0, 10, 0, 1, 0);
      cyc();
      ib.tgt_valid = 0;
      for (int k = 0; k < 4; k++) begin
         push("ovs_dn", 1, 0, 0, seq_dn[k], 0, seq_dn[k] != 0, k == 2);
         cyc();
      end

      // rate=3 with clk_half alternating: one step every 8 clocks
      ia.rate = 3; ia.tgt_valid = 1; ia.tgt0 = 20;
      for (int e = 1; e <= 24; e++) begin
         clk_half = (e % 2 == 1);
         push("rate", 0, 10 + int'(e >= 7) + int'(e >= 15) + int'(e >= 23),
              0, 0, 0, 1, 0);
         cyc();
         ia.tgt_valid = 0;
      end
      // clk_half held low: duties freeze
      clk_half = 1'b0;
      repeat (16) begin
         push("freeze", 0, 13, 0, 0, 0, 1, 0);
         cyc();
      end

      // Reset mid-fade clears everything with no done
      clk_half = 1'b1; ia.rate = 0; reset = 1'b1;
      push("reset_mid", 0, 0, 0, 0, 0, 0, 0);
      push("reset_mid", 1, 0, 0, 0, 0, 0, 0);
      cyc();
      reset = 1'b0;

      // Retarget mid-fade: 0 -> 200, redirected to 20 at duty 50
      ia.tgt_valid = 1; ia.tgt0 = 200;
      push("rt_latch", 0, 0, 0, 0, 0, 1, 0);
      cyc();
      ia.tgt_valid = 0;
      for (int i = 1; i <= 50; i++) begin
         push("rt_up", 0, i, 0, 0, 0, 1, 0);
         cyc();
      end
      ia.tgt_valid = 1; ia.tgt0 = 20;
      push("rt_switch", 0, 51, 0, 0, 0, 1, 0);
      cyc();
      ia.tgt_valid = 0;
      for (int v = 50; v >= 20; v--) begin
         push("rt_down", 0, v, 0, 0, 0, v != 20, v == 20);
         cyc();
      end
      push("rt_hold", 0, 20, 0, 0, 0, 0, 0);
      cyc();

      // Bypass: duty3 shows 255 two clocks after the strobe, never done
      ia.bypass = 1; ia.tgt_valid = 1; ia.tgt3 = 255;
      push("byp_latch", 0, 20, 0, 0, 0, 1, 0);
      cyc();
      ia.tgt_valid = 0;
      push("byp_out", 0, 20, 0, 0, 255, 0, 0);
      cyc();
      push("byp_hold", 0, 20, 0, 0, 255, 0, 0);
      cyc();

      // Leave bypass, fade duty3 toward 0, then reset mid-fade
      ia.bypass = 0; ia.tgt_valid = 1; ia.tgt3 = 0;
      push("fade_latch", 0, 20, 0, 0, 255, 1, 0);
      cyc();
      ia.tgt_valid = 0;
      push("fade_dn", 0, 20, 0, 0, 254, 1, 0);
      cyc();
      push("fade_dn", 0, 20, 0, 0, 253, 1, 0);
      cyc();
      reset = 1'b1;
      push("reset_abort", 0, 0, 0, 0, 0, 0, 0);
      push("reset_abort", 1, 0, 0, 0, 0, 0, 0);
      cyc();
      reset = 1'b0;
      push("post_reset", 0, 0, 0, 0, 0, 0, 0);
      push("post_reset", 1, 0, 0, 0, 0, 0, 0);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
